// File: rtl/ram_responder.sv
// Line-oriented RAM responder: one request moves a full line as LINE_BEATS beats.
// Reads return after LATENCY cycles; writes accept one beat per WR_VALID.
//   state       | meaning
//   IDLE        | waiting for an armed request
//   WAIT        | read access latency countdown
//   READ_BURST  | driving read beats on RD_DATA
//   WRITE_BURST | storing WR_DATA beats as they arrive
//   DONE        | one-cycle ACK, then back to IDLE
module ram_responder #(
   parameter int ADDR_SIZE  = 16,
   parameter int BUS_SIZE   = 16,
   parameter int LINE_BEATS = 8,
   parameter int MEM_LINES  = 64,
   parameter int LATENCY    = 2
) (
   input  logic                 RAM_CLK,
   input  logic                 RAM_RESET,
   input  logic                 REQ,
   input  logic                 READ_NOT_WRITE,
   input  logic [ADDR_SIZE-1:0] ADDR,
   input  logic [BUS_SIZE-1:0]  WR_DATA,
   input  logic                 WR_VALID,
   output logic [BUS_SIZE-1:0]  RD_DATA,
   output logic                 RD_VALID,
   output logic                 ACK,
   output logic                 BUSY
);

   localparam int OFFSET_W = $clog2(LINE_BEATS * BUS_SIZE / 8);
   localparam int LINE_W   = $clog2(MEM_LINES);
   localparam int BEAT_W   = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
   localparam logic [3:0]        WAIT_INIT = 4'(LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      READ_BURST,
      WRITE_BURST,
      DONE
   } state_t;

   state_t              state;
   logic                armed;
   logic [BEAT_W-1:0]   beat;
   logic [BEAT_W-1:0]   next_beat;
   logic [3:0]          wait_cnt;
   logic [LINE_W-1:0]   line_q;
   logic                wr_en;
   logic                unused_addr;

   logic [BUS_SIZE-1:0] mem [MEM_LINES][LINE_BEATS];

   // Byte offset within the line and address bits above the array alias away.
   assign unused_addr = ^ADDR;
   assign next_beat   = (beat == LAST_BEAT) ? '0 : beat + 1'b1;
   assign wr_en       = !RAM_RESET && (state == WRITE_BURST) && WR_VALID;

   // Storage has no reset so a reset mid-write keeps the beats already stored.
   always_ff @(posedge RAM_CLK) begin
      if (wr_en) begin
         mem[line_q][beat] <= WR_DATA;
      end
   end

   always_ff @(posedge RAM_CLK) begin
      if (RAM_RESET) begin
         state    <= IDLE;
         armed    <= 1'b1;
         beat     <= '0;
         wait_cnt <= '0;
         line_q   <= '0;
         RD_VALID <= 1'b0;
         RD_DATA  <= '0;
         ACK      <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         RD_VALID <= 1'b0;
         RD_DATA  <= '0;
         ACK      <= 1'b0;
         case (state)
            IDLE: begin
               if (REQ && armed) begin
                  armed  <= 1'b0;
                  line_q <= ADDR[OFFSET_W +: LINE_W];
                  beat   <= '0;
                  BUSY   <= 1'b1;
                  if (READ_NOT_WRITE) begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_INIT;
                  end else begin
                     state <= WRITE_BURST;
                  end
               end else if (!REQ) begin
                  armed <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state    <= READ_BURST;
                  RD_VALID <= 1'b1;
                  RD_DATA  <= mem[line_q][beat];
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            READ_BURST: begin
               beat <= next_beat;
               if (beat == LAST_BEAT) begin
                  state <= DONE;
                  ACK   <= 1'b1;
               end else begin
                  RD_VALID <= 1'b1;
                  RD_DATA  <= mem[line_q][next_beat];
               end
            end
            WRITE_BURST: begin
               if (WR_VALID) begin
                  beat <= next_beat;
                  if (beat == LAST_BEAT) begin
                     state <= DONE;
                     ACK   <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed vector table, hand-written
// reset/re-trigger sequences and random transfers against a line-array model.
module tb_ram_responder;

   localparam int ADDR_SIZE  = 16;
   localparam int BUS_SIZE   = 16;
   localparam int LINE_BEATS = 8;
   localparam int MEM_LINES  = 64;
   localparam int LATENCY    = 2;

   logic                 clk;
   logic                 RAM_RESET;
   logic                 REQ;
   logic                 READ_NOT_WRITE;
   logic [ADDR_SIZE-1:0] ADDR;
   logic [BUS_SIZE-1:0]  WR_DATA;
   logic                 WR_VALID;
   logic [BUS_SIZE-1:0]  RD_DATA;
   logic                 RD_VALID;
   logic                 ACK;
   logic                 BUSY;

   int checks   = 0;
   int failures = 0;

   logic [BUS_SIZE-1:0] ref_mem [MEM_LINES][LINE_BEATS];

   typedef struct {
      bit          rnw;
      logic [15:0] addr;
      logic [7:0]  stall;
      logic [15:0] base;
      int          exp_ack;
      int          hold;
   } vec_t;

   vec_t vecs[10];

   ram_responder #(
      .ADDR_SIZE (ADDR_SIZE),
      .BUS_SIZE  (BUS_SIZE),
      .LINE_BEATS(LINE_BEATS),
      .MEM_LINES (MEM_LINES),
      .LATENCY   (LATENCY)
   ) dut (
      .RAM_CLK       (clk),
      .RAM_RESET     (RAM_RESET),
      .REQ           (REQ),
      .READ_NOT_WRITE(READ_NOT_WRITE),
      .ADDR          (ADDR),
      .WR_DATA       (WR_DATA),
      .WR_VALID      (WR_VALID),
      .RD_DATA       (RD_DATA),
      .RD_VALID      (RD_VALID),
      .ACK           (ACK),
      .BUSY          (BUSY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete request; expectations come from the line model and the
   // cycle rules (read: LATENCY + beats, write: beats + stall cycles).
   task automatic xfer(input bit rnw, input logic [15:0] addr, input logic [7:0] stall,
                       input logic [15:0] base, input int exp_ack, input int hold);
      logic [BUS_SIZE-1:0] wd [LINE_BEATS];
      int line, sent, cyc, ack_cyc, first_rv, nrv, busy_bad, zero_bad, idle_bad;
      bit stalled;
      line = (int'(addr) >> 4) % MEM_LINES;
      for (int b = 0; b < LINE_BEATS; b++) wd[b] = base + BUS_SIZE'(b);
      sent = 0; cyc = 0; ack_cyc = -1; first_rv = -1; nrv = 0;
      busy_bad = 0; zero_bad = 0; idle_bad = 0; stalled = 1'b0;

      REQ = 1'b1; READ_NOT_WRITE = rnw; ADDR = addr; WR_VALID = 1'b0;
      tick();
      // Request fields must have been latched; scramble them now.
      ADDR = ADDR_SIZE'($urandom);
      READ_NOT_WRITE = !rnw;
      while (ack_cyc < 0 && cyc < 40) begin
         if (!rnw) begin
            if (sent < LINE_BEATS && stall[sent] && !stalled) begin
               WR_VALID = 1'b0; WR_DATA = BUS_SIZE'($urandom); stalled = 1'b1;
            end else if (sent < LINE_BEATS) begin
               WR_VALID = 1'b1; WR_DATA = wd[sent]; sent++; stalled = 1'b0;
            end else begin
               WR_VALID = 1'b0;
            end
         end else begin
            WR_VALID = 1'($urandom); WR_DATA = BUS_SIZE'($urandom);
         end
         tick();
         cyc++;
         if (ACK) ack_cyc = cyc;
         if (!BUSY) busy_bad++;
         if (RD_VALID) begin
            if (first_rv < 0) first_rv = cyc;
            if (nrv < LINE_BEATS)
               chk($sformatf("rd_beat%0d_line%0d", nrv, line), int'(RD_DATA), int'(ref_mem[line][nrv]));
            nrv++;
         end else if (RD_DATA != '0) begin
            zero_bad++;
         end
      end
      chk(rnw ? "rd_ack_cycle" : "wr_ack_cycle", ack_cyc, exp_ack);
      chk("busy_during_xfer_low_cycles", busy_bad, 0);
      if (rnw) begin
         chk("rd_first_valid_cycle", first_rv, LATENCY);
         chk("rd_beat_count", nrv, LINE_BEATS);
         chk("rd_data_nonzero_when_invalid", zero_bad, 0);
      end else if (ack_cyc >= 0) begin
         for (int b = 0; b < LINE_BEATS; b++) ref_mem[line][b] = wd[b];
      end

      for (int h = 0; h < hold + 2; h++) begin
         REQ = (h < hold);
         WR_VALID = 1'($urandom); WR_DATA = BUS_SIZE'($urandom);
         tick();
         if (ACK || BUSY || RD_VALID) idle_bad++;
      end
      WR_VALID = 1'b0;
      chk("idle_after_ack_activity", idle_bad, 0);
   endtask

   initial begin
      int ack_seen;
      bit rnw;
      logic [7:0] st;

      vecs[0] = '{1'b0, 16'h0010, 8'h00, 16'h1000,  8, 0};
      vecs[1] = '{1'b1, 16'h0010, 8'h00, 16'h0000, 10, 0};
      vecs[2] = '{1'b0, 16'h0020, 8'h24, 16'h2000, 10, 0};
      vecs[3] = '{1'b1, 16'h0020, 8'h00, 16'h0000, 10, 3};
      vecs[4] = '{1'b1, 16'h0010, 8'h00, 16'h0000, 10, 0};
      vecs[5] = '{1'b0, 16'h0410, 8'h00, 16'h3000,  8, 0};
      vecs[6] = '{1'b1, 16'h0010, 8'h00, 16'h0000, 10, 0};
      vecs[7] = '{1'b0, 16'h03F7, 8'h81, 16'h4000, 10, 1};
      vecs[8] = '{1'b1, 16'hFFF0, 8'h00, 16'h0000, 10, 0};
      vecs[9] = '{1'b1, 16'h0030, 8'h00, 16'h0000, 10, 0};

      RAM_RESET = 1'b1; REQ = 1'b1; READ_NOT_WRITE = 1'b1; ADDR = '0;
      WR_DATA = 16'hBEEF; WR_VALID = 1'b1;
      repeat (3) tick();
      chk("reset_rd_valid", int'(RD_VALID), 0);
      chk("reset_rd_data", int'(RD_DATA), 0);
      chk("reset_ack", int'(ACK), 0);
      chk("reset_busy", int'(BUSY), 0);
      RAM_RESET = 1'b0; REQ = 1'b0; WR_VALID = 1'b0;
      tick();

      for (int l = 0; l < MEM_LINES; l++)
         xfer(1'b0, 16'(l << 4), 8'h00, 16'($urandom), LINE_BEATS, 0);

      for (int i = 0; i < 10; i++)
         xfer(vecs[i].rnw, vecs[i].addr, vecs[i].stall, vecs[i].base, vecs[i].exp_ack, vecs[i].hold);

      // Reset arrives on the edge that would store beat 3 of line 5.
      REQ = 1'b1; READ_NOT_WRITE = 1'b0; ADDR = 16'h0050; WR_VALID = 1'b0;
      tick();
      for (int b = 0; b < 3; b++) begin
         WR_VALID = 1'b1; WR_DATA = 16'hA000 + 16'(b);
         tick();
      end
      WR_VALID = 1'b1; WR_DATA = 16'hA003; RAM_RESET = 1'b1;
      tick();
      chk("midwr_reset_rd_valid", int'(RD_VALID), 0);
      chk("midwr_reset_rd_data", int'(RD_DATA), 0);
      chk("midwr_reset_ack", int'(ACK), 0);
      chk("midwr_reset_busy", int'(BUSY), 0);
      RAM_RESET = 1'b0; REQ = 1'b0; WR_VALID = 1'b1; WR_DATA = 16'hA004;
      ack_seen = 0;
      repeat (10) begin
         tick();
         if (ACK || BUSY) ack_seen++;
      end
      WR_VALID = 1'b0;
      chk("midwr_reset_no_ack", ack_seen, 0);
      for (int b = 0; b < 3; b++) ref_mem[5][b] = 16'hA000 + 16'(b);
      xfer(1'b1, 16'h0050, 8'h00, 16'h0000, LATENCY + LINE_BEATS, 0);

      for (int i = 0; i < 40; i++) begin
         rnw = 1'($urandom);
         st  = 8'($urandom);
         xfer(rnw, 16'($urandom), st, 16'($urandom),
              rnw ? LATENCY + LINE_BEATS : LINE_BEATS + $countones(st),
              $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
